// File: rtl/core_pkg.sv
// core_pkg: shared constants for the core; PLIC register window offsets and source limit.
package core_pkg;
  localparam logic [11:0] PLIC_OFS_PRIO  = 12'h000;
  localparam logic [11:0] PLIC_OFS_PEND  = 12'h080;
  localparam logic [11:0] PLIC_OFS_EN    = 12'h100;
  localparam logic [11:0] PLIC_OFS_THR   = 12'h200;
  localparam logic [11:0] PLIC_OFS_CLAIM = 12'h204;
  localparam int PLIC_MAX_SRC = 31;
endpackage

// File: rtl/core_plic_gateway.sv
// core_plic_gateway: level-triggered gateway holding pending and in-flight state for one source.
module core_plic_gateway (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);
  logic in_flight;
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      pending   <= claim ? 1'b0 : pending | (irq & ~in_flight);
      in_flight <= claim | (in_flight & ~complete);
    end
  end
endmodule

// File: rtl/core_plic.sv
// core_plic: APB-attached lite PLIC driving int_m_ext with priority, enable, threshold and claim/complete.
// Define CORE_PLIC_SYNC_EN to pass irq_src through 2-flop synchronizers before the gateways.
module core_plic
  import core_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  output logic             pready,
  input  logic [11:0]      paddr,
  input  logic             pwrite,
  input  logic [31:0]      pwdata,
  input  logic [3:0]       pwstrb,
  output logic [31:0]      prdata,
  output logic             pslverr,
  input  logic [NUM_SRC:0] irq_src,
  output logic             int_m_ext
);
  logic acc, hit_prio, hit_pend, hit_en, hit_thr, hit_clm, err, rd, wr, clm_rd, cmp_wr;
  logic [NUM_SRC:1] irq_g, pend, en, elig, clm_v, cmp_v;
  logic [PRIO_W-1:0] prio [1:NUM_SRC];
  logic [PRIO_W-1:0] thr, win_p;
  logic [4:0] win_id;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{paddr[1:0], pwdata, irq_src[0]};
  assign acc = psel & penable;
  assign hit_prio = paddr[11:2] <= 10'(NUM_SRC);
  assign hit_pend = paddr[11:2] == PLIC_OFS_PEND[11:2];
  assign hit_en = paddr[11:2] == PLIC_OFS_EN[11:2];
  assign hit_thr = paddr[11:2] == PLIC_OFS_THR[11:2];
  assign hit_clm = paddr[11:2] == PLIC_OFS_CLAIM[11:2];
  assign err = acc & (~(hit_prio | hit_pend | hit_en | hit_thr | hit_clm) | (pwrite & (pwstrb != 4'hF)));
  assign rd = acc & ~pwrite & ~err;
  assign wr = acc & pwrite & ~err;
  assign clm_rd = rd & hit_clm;
  assign cmp_wr = wr & hit_clm;
  assign pready = acc;
  assign pslverr = err;
  assign prdata = rd ? rdata : '0;
`ifdef CORE_PLIC_SYNC_EN
  logic [NUM_SRC:1] sync1, sync2;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src[NUM_SRC:1];
      sync2 <= sync1;
    end
  end
  assign irq_g = sync2;
`else
  assign irq_g = irq_src[NUM_SRC:1];
`endif
  // Descending scan with >= lets the lowest ID win priority ties.
  always_comb begin
    win_id = '0;
    win_p = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      elig[i] = pend[i] & en[i] & (prio[i] > thr);
      if (elig[i] && prio[i] >= win_p) begin
        win_id = 5'(i);
        win_p = prio[i];
      end
    end
    for (int i = 1; i <= NUM_SRC; i++) begin
      clm_v[i] = clm_rd && win_id == 5'(i);
      cmp_v[i] = cmp_wr && pwdata[4:0] == 5'(i);
    end
  end
  always_comb begin
    rdata = '0;
    if (hit_pend) rdata = 32'({pend, 1'b0});
    if (hit_en) rdata = 32'({en, 1'b0});
    if (hit_thr) rdata = 32'(thr);
    if (hit_clm) rdata = 32'(win_id);
    for (int i = 1; i <= NUM_SRC; i++)
      if (hit_prio && paddr[6:2] == 5'(i)) rdata = 32'(prio[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en <= '0;
      thr <= '0;
      int_m_ext <= 1'b0;
      for (int i = 1; i <= NUM_SRC; i++) prio[i] <= '0;
    end else begin
      int_m_ext <= |elig;
      if (wr && hit_en) en <= pwdata[NUM_SRC:1];
      if (wr && hit_thr) thr <= pwdata[PRIO_W-1:0];
      for (int i = 1; i <= NUM_SRC; i++)
        if (wr && hit_prio && paddr[6:2] == 5'(i)) prio[i] <= pwdata[PRIO_W-1:0];
    end
  end
  for (genvar g = 1; g <= NUM_SRC; g++) begin : gw
    core_plic_gateway u_gw (
      .clk(clk),
      .rst(rst),
      .irq(irq_g[g]),
      .claim(clm_v[g]),
      .complete(cmp_v[g]),
      .pending(pend[g])
    );
  end
endmodule

// File: tb/tb_core_plic.sv
// tb_core_plic: directed plus randomized APB/irq stimulus checked against a behavioural PLIC model.
module tb_core_plic;
  localparam int N = 8;
  localparam int PW = 3;
  logic clk = 0, rst = 1, psel = 0, penable = 0, pwrite = 0, pready, pslverr, int_m_ext;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata;
  logic [3:0] pwstrb = '0;
  logic [N:0] irq_src = '0;
  int n_chk = 0, n_bad = 0;
  bit chk_on = 0;
  int m_prio [0:N];
  bit [N:0] m_pend, m_infl, m_en;
  int m_thr;
  bit m_int;
  bit [N:1] q1, q2;

  core_plic #(.NUM_SRC(N), .PRIO_W(PW)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pready(pready),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
    .prdata(prdata), .pslverr(pslverr), .irq_src(irq_src), .int_m_ext(int_m_ext)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit illegal(input logic [11:0] a, input bit w, input logic [3:0] s);
    int x = int'(a) / 4;
    return !(x <= N || a / 4 == 12'h080 / 4 || a / 4 == 12'h100 / 4 || a / 4 == 12'h200 / 4 || a / 4 == 12'h204 / 4)
           || (w && s != 4'hF);
  endfunction

  // Highest priority among pending, enabled, above-threshold sources; first found wins ties.
  function automatic int winner();
    int best = 0;
    for (int id = 1; id <= N; id++)
      if (m_pend[id] && m_en[id] && m_prio[id] > m_thr && (best == 0 || m_prio[id] > m_prio[best])) best = id;
    return best;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    int x = int'(a) / 4;
    if (illegal(a, 0, 4'hF)) return 0;
    if (x >= 1 && x <= N) return m_prio[x];
    if (a / 4 == 12'h080 / 4) return 32'(m_pend);
    if (a / 4 == 12'h100 / 4) return 32'(m_en);
    if (a / 4 == 12'h200 / 4) return m_thr;
    if (a / 4 == 12'h204 / 4) return winner();
    return 0;
  endfunction

  always @(posedge clk) begin
    bit [N:0] irq_eff;
    bit acc, e, nint;
    int cl, cp, x;
    if (rst) begin
      m_pend = 0; m_infl = 0; m_en = 0; m_thr = 0; m_int = 0; q1 = 0; q2 = 0;
      for (int i = 0; i <= N; i++) m_prio[i] = 0;
    end else begin
`ifdef CORE_PLIC_SYNC_EN
      irq_eff = {q2, 1'b0}; q2 = q1; q1 = irq_src[N:1];
`else
      irq_eff = irq_src;
`endif
      nint = winner() != 0;
      acc = psel && penable;
      e = illegal(paddr, pwrite, pwstrb);
      x = int'(paddr) / 4;
      cl = (acc && !pwrite && !e && paddr / 4 == 12'h204 / 4) ? winner() : 0;
      cp = (acc && pwrite && !e && paddr / 4 == 12'h204 / 4) ? int'(pwdata[4:0]) : 0;
      if (acc && pwrite && !e) begin
        if (x >= 1 && x <= N) m_prio[x] = pwdata % (1 << PW);
        if (paddr / 4 == 12'h100 / 4) m_en = pwdata[N:0] & ~(N+1)'(1);
        if (paddr / 4 == 12'h200 / 4) m_thr = pwdata % (1 << PW);
      end
      for (int i = 1; i <= N; i++) begin
        if (i == cl) m_pend[i] = 0;
        else if (irq_eff[i] && !m_infl[i]) m_pend[i] = 1;
        if (i == cl) m_infl[i] = 1;
        else if (i == cp) m_infl[i] = 0;
      end
      m_int = nint;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("int_m_ext", 32'(int_m_ext), 32'(m_int));
    chk("pready", 32'(pready), 32'(psel & penable));
    if (psel && penable) begin
      chk("pslverr", 32'(pslverr), 32'(illegal(paddr, pwrite, pwstrb)));
      if (!pwrite) chk("prdata", prdata, exp_rd(paddr));
    end else begin
      chk("idle_prdata", prdata, 0);
      chk("idle_pslverr", 32'(pslverr), 0);
    end
  end

  task automatic apb(input bit w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output logic e);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d; pwstrb = s;
    @(posedge clk); #1 penable = 1;
    @(negedge clk); r = prdata; e = pslverr;
    @(posedge clk); #1 psel = 0; penable = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r; logic e;
    apb(1, a, d, 4'hF, r, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [31:0] r; logic e;
    idle(3);
    rst = 0; chk_on = 1;
    apb(0, 12'h080, 0, 0, r, e); chk("rst_pend", r, 0); chk("rst_err", 32'(e), 0);
    apb(0, 12'h100, 0, 0, r, e); chk("rst_en", r, 0);
    apb(0, 12'h200, 0, 0, r, e); chk("rst_thr", r, 0);
    apb(0, 12'h204, 0, 0, r, e); chk("rst_claim", r, 0);
    chk("rst_int", 32'(int_m_ext), 0);
    wr(12'h00C, 2); wr(12'h100, 32'h08); wr(12'h200, 1);
    irq_src[3] = 1;
    idle(5);
    chk("t2_int", 32'(int_m_ext), 1);
    apb(0, 12'h204, 0, 0, r, e); chk("t2_claim", r, 3);
    apb(0, 12'h080, 0, 0, r, e); chk("t2_pend_clr", r, 0);
    wr(12'h204, 3);
    idle(3);
    apb(0, 12'h080, 0, 0, r, e); chk("t2_repend", r, 32'h08);
    irq_src[3] = 0;
    wr(12'h008, 5); wr(12'h014, 5); wr(12'h018, 7); wr(12'h200, 0); wr(12'h100, 32'h64);
    irq_src[2] = 1; irq_src[5] = 1; irq_src[6] = 1;
    idle(4);
    irq_src[2] = 0; irq_src[5] = 0; irq_src[6] = 0;
    apb(0, 12'h204, 0, 0, r, e); chk("t3_c6", r, 6);
    apb(0, 12'h204, 0, 0, r, e); chk("t3_c2", r, 2);
    apb(0, 12'h204, 0, 0, r, e); chk("t3_c5", r, 5);
    apb(0, 12'h204, 0, 0, r, e); chk("t3_c0", r, 0);
    wr(12'h204, 6); wr(12'h204, 2); wr(12'h204, 5);
    wr(12'h200, 5); wr(12'h010, 5); wr(12'h100, 32'h10);
    irq_src[4] = 1;
    idle(5);
    chk("t4_int_lo", 32'(int_m_ext), 0);
    wr(12'h200, 4);
    idle(1);
    chk("t4_int_hi", 32'(int_m_ext), 1);
    apb(0, 12'h300, 0, 0, r, e); chk("t5_bad_err", 32'(e), 1); chk("t5_bad_data", r, 0);
    apb(1, 12'h100, 32'hFF, 4'h3, r, e); chk("t5_strb_err", 32'(e), 1);
    apb(0, 12'h100, 0, 0, r, e); chk("t5_en_kept", r, 32'h10);
    apb(1, 12'h204, 9, 4'hF, r, e); chk("t5_cmp9_err", 32'(e), 0);
    irq_src[4] = 0;
    wr(12'h004, 7); wr(12'h100, 32'h02);
    irq_src[1] = 1;
    idle(4);
    apb(0, 12'h204, 0, 0, r, e); chk("t6_claim1", r, 1);
    rst = 1; idle(2); rst = 0;
    wr(12'h004, 7); wr(12'h100, 32'h02);
    idle(4);
    apb(0, 12'h080, 0, 0, r, e); chk("t6_repend", r, 32'h02);
    for (int k = 0; k < 400; k++) begin
      int op = $urandom_range(0, 7);
      irq_src[$urandom_range(1, N)] ^= 1'b1;
      case (op)
        0: wr(12'(4 * $urandom_range(0, N + 1)), $urandom);
        1: wr(12'h100, $urandom);
        2: wr(12'h200, $urandom_range(0, 3));
        3, 4: apb(0, 12'h204, 0, 0, r, e);
        5: wr(12'h204, $urandom_range(0, N + 2));
        6: apb(0, 12'($urandom_range(0, 4095)), 0, 0, r, e);
        default: apb(1, 12'($urandom_range(0, 4095)), $urandom, 4'($urandom), r, e);
      endcase
      idle($urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
